// File: rtl/pcie_rst_seq_pkg.sv
// rtl/pcie_rst_seq_pkg.sv - shared types and defaults for the PCIe reset/link-bring-up sequencer
//
// Contents: sequencer state enum (encodings visible on the state output),
// default phase lengths, the registered-output bundle and the per-state
// output decode used by the top.

package pcie_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_POR_REL   = 3'd1,
        ST_WAIT_LINK = 3'd2,
        ST_UP        = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    localparam int DEF_ASSERT_CYCLES = 500;
    localparam int DEF_POR_TO_PERST  = 16;
    localparam int DEF_LINK_TIMEOUT  = 65535;
    localparam int DEF_MAX_RETRY     = 3;
    localparam int DEF_CNT_W         = 17;

    typedef struct packed {
        logic       por_n;
        logic       cpm_por_n;
        logic       rp_rst_n;
        logic [1:0] perst_n;
        logic       seq_done;
        logic       link_fail;
    } seq_out_t;

    // Output pattern held while in a given state. FAIL keeps the WAIT_LINK
    // reset levels so the board is not bounced when giving up.
    function automatic seq_out_t outputs_for(seq_state_t s);
        seq_out_t o;
        o = '0;
        case (s)
            ST_POR_REL: begin
                o.por_n     = 1'b1;
                o.cpm_por_n = 1'b1;
                o.rp_rst_n  = 1'b1;
            end
            ST_WAIT_LINK, ST_UP, ST_FAIL: begin
                o.por_n     = 1'b1;
                o.cpm_por_n = 1'b1;
                o.rp_rst_n  = 1'b1;
                o.perst_n   = 2'b11;
            end
            default: o = '0;
        endcase
        o.seq_done  = (s == ST_UP);
        o.link_fail = (s == ST_FAIL);
        return o;
    endfunction

endpackage

// File: rtl/pcie_rst_sync_2ff.sv
// rtl/pcie_rst_sync_2ff.sv - generic two-flop synchronizer, async active-low reset to 0
//
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset
//   d      in  W  asynchronous input
//   q      out W  synchronized output (two clocks of latency)

module pcie_rst_sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_rst_seq.sv
// rtl/pcie_rst_seq.sv - staged reset and link-bring-up sequencer for the CPM5 EP/RP board
//
// Optional feature: define PCIE_RST_SEQ_RETRY_EN to retry the sequence up to
// MAX_RETRY times on link timeout or link loss; otherwise the first failure
// goes straight to FAIL and retry_cnt stays 0.
//
// Ports:
//   sys_clk       in  1  sequencer clock (100 MHz reference)
//   sys_rst_n     in  1  asynchronous active-low reset
//   soft_rst_req  in  1  one-cycle pulse, restarts the sequence from ASSERT
//   link_up       in  1  asynchronous link-up status from the root port
//   por_n         out 1  PS-VIP POR release, EP and RP
//   cpm_por_n     out 1  LPD CPM5 POR_N, EP and RP
//   rp_rst_n      out 1  root-port sys_rst_n
//   perst_n       out 2  PERST1N/PERST0N, EP and RP
//   seq_done      out 1  high while the link is up after a sequence
//   link_fail     out 1  sticky failure flag, cleared by soft_rst_req
//   state         out 3  current state
//   retry_cnt     out 2  retries taken, saturating

module pcie_rst_seq
    import pcie_rst_seq_pkg::*;
#(
    parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
    parameter int POR_TO_PERST  = DEF_POR_TO_PERST,
    parameter int LINK_TIMEOUT  = DEF_LINK_TIMEOUT,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       soft_rst_req,
    input  logic       link_up,
    output logic       por_n,
    output logic       cpm_por_n,
    output logic       rp_rst_n,
    output logic [1:0] perst_n,
    output logic       seq_done,
    output logic       link_fail,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);

`ifdef PCIE_RST_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    // Clamp so the 2-bit counter saturates instead of wrapping.
    localparam int unsigned RETRY_LIM = (MAX_RETRY > 3) ? 3 : MAX_RETRY;

    // A timed state of N cycles leaves on the edge where the counter is N-1.
    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERST_LAST  = CNT_W'(POR_TO_PERST - 1);
    localparam logic [CNT_W-1:0] LINK_LAST   = CNT_W'(LINK_TIMEOUT - 1);

    logic             link_up_s;
    seq_state_t       cur;
    seq_state_t       nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       retry_q;
    seq_out_t         out_q;
    logic             retry_ok;
    logic             take_retry;

    pcie_rst_sync_2ff #(
        .W(1)
    ) u_link_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (link_up),
        .q     (link_up_s)
    );

    assign retry_ok = RETRY_EN && ({30'd0, retry_q} < RETRY_LIM);

    always_comb begin
        nxt        = cur;
        take_retry = 1'b0;
        if (soft_rst_req) begin
            nxt = ST_ASSERT;
        end else begin
            case (cur)
                ST_ASSERT: begin
                    if (cnt == ASSERT_LAST) nxt = ST_POR_REL;
                end
                ST_POR_REL: begin
                    if (cnt == PERST_LAST) nxt = ST_WAIT_LINK;
                end
                ST_WAIT_LINK: begin
                    // Link-up beats a timeout landing on the same cycle.
                    if (link_up_s) begin
                        nxt = ST_UP;
                    end else if (cnt == LINK_LAST) begin
                        nxt        = retry_ok ? ST_ASSERT : ST_FAIL;
                        take_retry = retry_ok;
                    end
                end
                ST_UP: begin
                    if (!link_up_s) begin
                        nxt        = retry_ok ? ST_ASSERT : ST_FAIL;
                        take_retry = retry_ok;
                    end
                end
                ST_FAIL:  nxt = ST_FAIL;
                default:  nxt = ST_ASSERT;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur     <= ST_ASSERT;
            cnt     <= '0;
            retry_q <= '0;
            out_q   <= '0;
        end else begin
            cur   <= nxt;
            out_q <= outputs_for(nxt);

            if (soft_rst_req || (nxt != cur)) begin
                cnt <= '0;
            end else if ((cur == ST_ASSERT) || (cur == ST_POR_REL) || (cur == ST_WAIT_LINK)) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (soft_rst_req) begin
                retry_q <= '0;
            end else if (take_retry) begin
                retry_q <= retry_q + 2'd1;
            end
        end
    end

    assign por_n     = out_q.por_n;
    assign cpm_por_n = out_q.cpm_por_n;
    assign rp_rst_n  = out_q.rp_rst_n;
    assign perst_n   = out_q.perst_n;
    assign seq_done  = out_q.seq_done;
    assign link_fail = out_q.link_fail;
    assign state     = cur;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pcie_rst_seq.sv
// tb/tb_pcie_rst_seq.sv - self-checking bench for pcie_rst_seq against a cycle-time reference model

module tb_pcie_rst_seq;

    localparam int A  = 500;
    localparam int P  = 16;
    localparam int T  = 100;
    localparam int MR = 3;

`ifdef PCIE_RST_SEQ_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    localparam int S_ASSERT = 0;
    localparam int S_POR    = 1;
    localparam int S_WAIT   = 2;
    localparam int S_UP     = 3;
    localparam int S_FAIL   = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       soft_rst_req;
    logic       link_up;
    logic       por_n;
    logic       cpm_por_n;
    logic       rp_rst_n;
    logic [1:0] perst_n;
    logic       seq_done;
    logic       link_fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [11:0] dut_vec;

    always #5 sys_clk = ~sys_clk;

    pcie_rst_seq #(
        .ASSERT_CYCLES (A),
        .POR_TO_PERST  (P),
        .LINK_TIMEOUT  (T),
        .MAX_RETRY     (MR),
        .CNT_W         (17)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .soft_rst_req (soft_rst_req),
        .link_up      (link_up),
        .por_n        (por_n),
        .cpm_por_n    (cpm_por_n),
        .rp_rst_n     (rp_rst_n),
        .perst_n      (perst_n),
        .seq_done     (seq_done),
        .link_fail    (link_fail),
        .state        (state),
        .retry_cnt    (retry_cnt)
    );

    assign dut_vec = {state, retry_cnt, por_n, cpm_por_n, rp_rst_n, perst_n, seq_done, link_fail};

    int checks = 0;
    int errors = 0;

    // Reference model: clock edges counted since reset release; each stage
    // remembers the edge it was entered on and leaves at entry + length.
    int cyc;
    int m_stage;
    int m_enter;
    int m_retry;
    bit lu_pipe[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_stage = S_ASSERT;
        m_enter = 0;
        m_retry = 0;
        cyc     = 0;
        lu_pipe = '{1'b0, 1'b0};
    endtask

    task automatic enter(input int s);
        m_stage = s;
        m_enter = cyc;
    endtask

    task automatic lose_link();
        if (RETRY_ON && (m_retry < MR)) begin
            m_retry++;
            enter(S_ASSERT);
        end else begin
            enter(S_FAIL);
        end
    endtask

    task automatic model_step();
        bit seen;
        // link_up as seen by the sequencer lags the pin by two edges
        seen = lu_pipe.pop_front();
        lu_pipe.push_back(link_up);
        if (soft_rst_req) begin
            m_retry = 0;
            enter(S_ASSERT);
        end else begin
            case (m_stage)
                S_ASSERT: if (cyc == m_enter + A) enter(S_POR);
                S_POR:    if (cyc == m_enter + P) enter(S_WAIT);
                S_WAIT: begin
                    if (seen) enter(S_UP);
                    else if (cyc == m_enter + T) lose_link();
                end
                S_UP:     if (!seen) lose_link();
                default:  ;
            endcase
        end
    endtask

    function automatic logic [11:0] expect_vec();
        logic [4:0] rst;
        logic [2:0] st;
        logic [1:0] rc;
        st  = m_stage[2:0];
        rc  = m_retry[1:0];
        rst = (m_stage == S_ASSERT) ? 5'b00000 :
              (m_stage == S_POR)    ? 5'b11100 : 5'b11111;
        return {st, rc, rst, m_stage == S_UP, m_stage == S_FAIL};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        if (sys_rst_n) begin
            cyc++;
            model_step();
        end
        #1;
        check("outputs", 32'(dut_vec), 32'(expect_vec()));
    endtask

    task automatic run_until(input int st, input int bound, input string tag);
        for (int i = 0; (i < bound) && (m_stage != st); i++) tick();
        check(tag, 32'(state), 32'(st));
    endtask

    initial begin
        int s0;
        sys_rst_n    = 1'b0;
        soft_rst_req = 1'b0;
        link_up      = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_state", 32'(dut_vec), 32'd0);

        // Power-on sequence with the link never coming up
        sys_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 620; i++) begin
            tick();
            if (cyc == 499) check("por_low_499", 32'(por_n), 32'd0);
            if (cyc == 500) check("por_rise_500", 32'(por_n), 32'd1);
            if (cyc == 515) check("perst_low_515", 32'(perst_n), 32'd0);
            if (cyc == 516) check("perst_rise_516", 32'(perst_n), 32'd3);
            if (cyc == 615) check("wait_615", 32'(state), 32'(S_WAIT));
            if (cyc == 616) begin
                check("state_616", 32'(state), RETRY_ON ? 32'(S_ASSERT) : 32'(S_FAIL));
                check("link_fail_616", 32'(link_fail), 32'(!RETRY_ON));
                check("retry_616", 32'(retry_cnt), 32'(RETRY_ON));
            end
        end
        run_until(S_FAIL, 3000, "reach_fail");
        check("fail_flag", 32'(link_fail), 32'd1);
        check("fail_retry", 32'(retry_cnt), RETRY_ON ? 32'(MR) : 32'd0);

        // Soft restart from FAIL, link comes up 550 cycles in
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check("soft_state", 32'(state), 32'(S_ASSERT));
        check("soft_fail_clr", 32'(link_fail), 32'd0);
        check("soft_retry_clr", 32'(retry_cnt), 32'd0);
        s0 = cyc;
        while (cyc < s0 + 550) tick();
        link_up = 1'b1;
        repeat (2) tick();
        check("done_low_552", 32'(seq_done), 32'd0);
        tick();
        check("done_553", 32'(seq_done), 32'd1);
        check("no_fail_553", 32'(link_fail), 32'd0);

        // Link loss while up
        repeat ($urandom_range(5, 40)) tick();
        link_up = 1'b0;
        repeat (3) tick();
        check("loss_state", 32'(state), RETRY_ON ? 32'(S_ASSERT) : 32'(S_FAIL));
        check("loss_resets", 32'({por_n, cpm_por_n, rp_rst_n, perst_n}), RETRY_ON ? 32'd0 : 32'd31);
        check("loss_retry", 32'(retry_cnt), 32'(RETRY_ON));

        // Soft restart in the middle of POR_REL
        if (m_stage == S_FAIL) begin
            soft_rst_req = 1'b1;
            tick();
            soft_rst_req = 1'b0;
        end
        run_until(S_POR, 700, "reach_por");
        repeat ($urandom_range(1, 14)) tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check("midpor_state", 32'(state), 32'(S_ASSERT));
        check("midpor_retry", 32'(retry_cnt), 32'd0);
        check("midpor_por", 32'(por_n), 32'd0);
        s0 = cyc;
        while (cyc < s0 + 499) tick();
        check("restart_por_low", 32'(por_n), 32'd0);
        tick();
        check("restart_por_rise", 32'(por_n), 32'd1);

        // Randomized link activity and occasional soft restarts
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) link_up = ~link_up;
            soft_rst_req = ($urandom_range(0, 1499) == 0);
            tick();
        end
        soft_rst_req = 1'b0;
        link_up      = 1'b0;

        // Asynchronous reset in the middle of WAIT_LINK
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        run_until(S_WAIT, 700, "reach_wait");
        repeat ($urandom_range(1, 50)) tick();
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_zero", 32'(dut_vec), 32'd0);
        model_reset();
        repeat (2) tick();
        sys_rst_n = 1'b1;
        model_reset();
        while (cyc < 499) tick();
        check("rerel_por_low", 32'(por_n), 32'd0);
        tick();
        check("rerel_por_rise", 32'(por_n), 32'd1);
        check("rerel_state", 32'(state), 32'(S_POR));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_rst_seq.md
# pcie_rst_seq

Reset and link-bring-up sequencer that drives the staged resets of the CPM5 endpoint and root-port halves of the BMD simulation board. It sits directly upstream of the board top and replaces its hand-written reset block. It asserts power-on, LPD CPM POR and PERST resets in a fixed order with programmable spacing, then watches link-up with a timeout. It reports done or failure to the test sequence.

## Interface
- ASSERT_CYCLES, 500: clocks all reset outputs are held low after sequence start.
- POR_TO_PERST, 16: clocks between POR/CPM-POR release and PERST release.
- LINK_TIMEOUT, 65535: clocks allowed in WAIT_LINK before timeout.
- MAX_RETRY, 3: retry limit. Used only when retry is compiled in.
- CNT_W, 17: phase counter width. It must hold max(ASSERT_CYCLES, POR_TO_PERST, LINK_TIMEOUT).

Ports:
- sys_clk  in  1  sequencer clock; the 100 MHz reference clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- soft_rst_req  in  1  synchronous one-cycle pulse that restarts the sequence.
- link_up  in  1  asynchronous link-up status from the root port.
- por_n  out  1  PS-VIP POR release for EP and RP.
- cpm_por_n  out  1  LPD CPM5 POR_N for EP and RP.
- rp_rst_n  out  1  root-port sys_rst_n.
- perst_n  out  2  PERST1N/PERST0N, EP and RP.
- seq_done  out  1  high while the link is up after a sequence.
- link_fail  out  1  sticky failure flag.
- state  out  3  current FSM state.
- retry_cnt  out  2  number of retries taken.

## Operation
- FSM encoding:
  - ASSERT = 0
  - POR_REL = 1
  - WAIT_LINK = 2
  - UP = 3
  - FAIL = 4
- Counter rule: one phase counter, cleared on every state entry. A timed state of N cycles exits on the edge where the counter equals N-1.
- ASSERT:
  - All reset outputs are 0.
  - Lasts ASSERT_CYCLES cycles, then goes to POR_REL.
- POR_REL:
  - por_n, cpm_por_n and rp_rst_n are 1; perst_n is 2'b00.
  - Lasts POR_TO_PERST cycles, then goes to WAIT_LINK.
- WAIT_LINK:
  - perst_n is 2'b11.
  - If synchronized link_up = 1, go to UP.
  - Else, if the counter equals LINK_TIMEOUT-1, take the timeout path.
  - If both happen on the same cycle, link_up wins.
- UP:
  - seq_done = 1.
  - If synchronized link_up falls, take the link-loss path, identical to the timeout path.
- Timeout/loss path:
  - Retry compiled in and retry_cnt < MAX_RETRY: increment retry_cnt, go to ASSERT.
  - Otherwise: go to FAIL.
- FAIL:
  - All reset outputs keep their WAIT_LINK values.
  - seq_done = 0, link_fail = 1.
  - Holds until soft_rst_req.
- soft_rst_req:
  - Works from any state and has priority over every other transition.
  - Next state is ASSERT, retry_cnt and link_fail clear, counter clears.
- link_up passes through a 2-flop synchronizer before use. All outputs are registered.

## Timing
- Reset values: every output is 0, including state = ASSERT and retry_cnt = 0.
- After sys_rst_n rises, the ASSERT phase runs without a request.
- Assertion of sys_rst_n mid-sequence forces all outputs to 0 immediately (asynchronous). The sequence then restarts from ASSERT.
- Release spacing:
  - por_n rises exactly ASSERT_CYCLES clocks after sys_rst_n release or a soft_rst_req edge.
  - perst_n rises POR_TO_PERST clocks after that.
- seq_done rises 3 clocks after link_up rises: 2 synchronizer clocks plus 1 state clock.
- On link loss, seq_done falls 3 clocks after link_up falls.
- Re-entering ASSERT drops all resets on the next clock edge.
- retry_cnt saturates at MAX_RETRY and never wraps.

## Configuration
- Macro PCIE_RST_SEQ_RETRY_EN.
- Defined: timeout or link loss retries up to MAX_RETRY times, then goes to FAIL.
- Undefined:
  - The first timeout or link loss goes straight to FAIL.
  - retry_cnt is tied to 0 and MAX_RETRY is ignored.

## Structure
- Package pcie_rst_seq_pkg holds:
  - the state enum with the encodings above;
  - default constants for the phase lengths.
- Sub-module pcie_rst_sync_2ff: generic 2-flop synchronizer with async active-low reset, reset value 0. Used for link_up.

## Test plan
- Release sys_rst_n, link_up tied 0, retry off, LINK_TIMEOUT=100 -> por_n rises at cycle 500, perst_n = 2'b11 at 516, state = FAIL and link_fail = 1 at cycle 616.
- link_up rises at cycle 550 -> seq_done = 1 at cycle 553; link_fail stays 0.
- Retry on, MAX_RETRY=3, link never up -> three returns to ASSERT with retry_cnt 1, 2, 3, then FAIL.
- In UP, link_up drops:
  - Retry on -> state = ASSERT 3 clocks later, all resets 0, retry_cnt increments.
  - Retry off -> state = FAIL.
- soft_rst_req in FAIL and again mid-POR_REL -> next cycle state = ASSERT, link_fail = 0, retry_cnt = 0, full timing restarts.
- sys_rst_n asserted mid-WAIT_LINK -> all outputs 0 within the same time step with no clock edge; after release the sequence restarts.
